// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, single-cycle ALU and EX/MEM register.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit (codes 16-23).
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            alu_src_b,
    input  logic            use_pc_a,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] ex_mem_fwd_data,
    input  logic [XLEN-1:0] mem_wb_fwd_data,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            flush,
    output logic            ex_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write
);
    localparam int SHW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] alu_f(input logic [4:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << sh;
            5'd6:    r = a >> sh;
            5'd7:    r = $unsigned($signed(a) >>> sh);
            5'd8:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'd9:    r = {{(XLEN-1){1'b0}}, (a < b)};
            5'd10:   r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu;
    logic            w_nx_valid, w_nx_rw;
    logic [XLEN-1:0] w_nx_result, w_nx_store;
    logic [4:0]      w_nx_rd;

    // Forwarding selects first; select code 11 falls back to the ID/EX value.
    always_comb begin
        case (forward_a)
            2'b01:   w_fwd_a = ex_mem_fwd_data;
            2'b10:   w_fwd_a = mem_wb_fwd_data;
            default: w_fwd_a = rs1_data;
        endcase
        case (forward_b)
            2'b01:   w_fwd_b = ex_mem_fwd_data;
            2'b10:   w_fwd_b = mem_wb_fwd_data;
            default: w_fwd_b = rs2_data;
        endcase
    end

    assign w_op_a = use_pc_a  ? pc  : w_fwd_a;
    assign w_op_b = alu_src_b ? imm : w_fwd_b;
    assign w_alu  = alu_f(alu_op, w_op_a, w_op_b);

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    state_t            r_state;
    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo, r_div;
    logic [2:0]        r_op;
    logic              r_neg, r_bzero;

    logic              w_is_iter, w_a_sgn, w_b_sgn, w_sa, w_sb, w_neg, w_dge;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_iter_res;
    logic [XLEN:0]     w_madd, w_dshift, w_dsub;
    logic [2*XLEN-1:0] w_prod, w_prod_s;

    assign w_is_iter = (alu_op[4:3] == 2'b10);
    // Mul ops: MUL/MULH/MULHSU treat A as signed, MUL/MULH treat B as signed.
    assign w_a_sgn = alu_op[2] ? ~alu_op[0] : (alu_op[1:0] != 2'b11);
    assign w_b_sgn = alu_op[2] ? ~alu_op[0] : ~alu_op[1];
    assign w_sa    = w_a_sgn & w_op_a[XLEN-1];
    assign w_sb    = w_b_sgn & w_op_b[XLEN-1];
    assign w_mag_a = w_sa ? (~w_op_a + 1'b1) : w_op_a;
    assign w_mag_b = w_sb ? (~w_op_b + 1'b1) : w_op_b;
    assign w_neg   = (alu_op[2] & alu_op[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_div} : {(XLEN+1){1'b0}});
    assign w_dshift = {r_hi, r_lo[XLEN-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_div});
    assign w_dsub   = w_dshift - {1'b0, r_div};

    // Sign correction; a zero divisor forces an all-ones quotient.
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = r_bzero ? '1 : (r_neg ? (~r_lo + 1'b1) : r_lo);
    assign w_rem    = r_neg ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        case (r_op)
            3'd0:          w_iter_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          w_iter_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    w_iter_res = w_quo;
            default:       w_iter_res = w_rem;
        endcase
    end

    assign ex_stall = in_valid & w_is_iter & (r_state != S_DONE) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid && w_is_iter) begin
                    r_op    <= alu_op[2:0];
                    r_neg   <= w_neg;
                    r_bzero <= (w_op_b == '0);
                    r_hi    <= '0;
                    r_lo    <= w_mag_a;
                    r_div   <= w_mag_b;
                    r_cnt   <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (r_op[2]) begin
                        r_hi <= w_dge ? w_dsub[XLEN-1:0] : w_dshift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_dge};
                    end else begin
                        r_hi <= w_madd[XLEN:1];
                        r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign ex_stall = 1'b0;
`endif

    // Next EX/MEM contents; anything not written here is a bubble.
    always_comb begin
        w_nx_valid  = 1'b0;
        w_nx_result = '0;
        w_nx_store  = '0;
        w_nx_rd     = '0;
        w_nx_rw     = 1'b0;
`ifdef EX_MULDIV_EN
        if (!flush && r_state == S_DONE) begin
            w_nx_valid  = 1'b1;
            w_nx_result = w_iter_res;
            w_nx_store  = w_fwd_b;
            w_nx_rd     = rd;
            w_nx_rw     = reg_write;
        end else if (!flush && r_state == S_IDLE && in_valid && !w_is_iter) begin
`else
        if (!flush && in_valid) begin
`endif
            w_nx_valid  = 1'b1;
            w_nx_result = w_alu;
            w_nx_store  = w_fwd_b;
            w_nx_rd     = rd;
            w_nx_rw     = reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
        end else begin
            out_valid      <= w_nx_valid;
            out_result     <= w_nx_result;
            out_store_data <= w_nx_store;
            out_rd         <= w_nx_rd;
            out_reg_write  <= w_nx_rw;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; iterative-unit cases build only with EX_MULDIV_EN.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, alu_src_b, use_pc_a, reg_write, flush;
    logic [4:0]  alu_op, rd;
    logic [31:0] rs1_data, rs2_data, imm, pc, ex_mem_fwd_data, mem_wb_fwd_data;
    logic [1:0]  forward_a, forward_b;
    logic        ex_stall, out_valid, out_reg_write;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .alu_src_b(alu_src_b), .use_pc_a(use_pc_a),
        .forward_a(forward_a), .forward_b(forward_b),
        .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
        .rd(rd), .reg_write(reg_write), .flush(flush), .ex_stall(ex_stall),
        .out_valid(out_valid), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    // Monitor: every valid EX/MEM entry must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got res=%h rd=%0d, expected no valid output",
                         out_result, out_rd);
            end else begin
                m_e = q.pop_front();
                if (out_result !== m_e.res || out_store_data !== m_e.st ||
                    out_rd !== m_e.rd || out_reg_write !== m_e.rw) begin
                    n_fail++;
                    $display("FAIL %s: got res=%h st=%h rd=%0d rw=%b, want res=%h st=%h rd=%0d rw=%b",
                             m_e.name, out_result, out_store_data, out_rd, out_reg_write,
                             m_e.res, m_e.st, m_e.rd, m_e.rw);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic push(input string nm, input logic [31:0] res, input logic [31:0] st,
                        input logic [4:0] d);
        exp_t e;
        e.name = nm; e.res = res; e.st = st; e.rd = d; e.rw = 1'b1;
        q.push_back(e);
    endtask

    task automatic plain(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; alu_op = op; rs1_data = a; rs2_data = b; rd = op; reg_write = 1'b1;
        forward_a = 2'b00; forward_b = 2'b00; alu_src_b = 1'b0; use_pc_a = 1'b0; flush = 1'b0;
    endtask

    task automatic alu1(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want);
        plain(op, a, b);
        push(nm, want, b, op);
        step();
    endtask

    task automatic do_iter(input string nm, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] want);
        int cnt;
        plain(op, a, b);
        push(nm, want, b, op);
        #1;
        cnt = 0;
        while (ex_stall && cnt < 100) begin
            cnt++;
            step();
        end
        chk({nm, "_stall_cycles"}, cnt, 33);
        step();
        chk({nm, "_valid"}, {31'b0, out_valid}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_op = '0; rs1_data = '0; rs2_data = '0;
        imm = '0; pc = '0; alu_src_b = 1'b0; use_pc_a = 1'b0; forward_a = '0;
        forward_b = '0; ex_mem_fwd_data = '0; mem_wb_fwd_data = '0; rd = '0;
        reg_write = 1'b0; flush = 1'b0;
        repeat (3) step();
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_result", out_result, 0);
        chk("rst_store", out_store_data, 0);
        chk("rst_rd", {27'b0, out_rd}, 0);
        chk("rst_rw", {31'b0, out_reg_write}, 0);
        chk("rst_stall", {31'b0, ex_stall}, 0);
        rst = 1'b0;
        step();

        // Forwarding: EX/MEM on A, then code 11 falls back to ID/EX.
        plain(5'd0, 32'd5, 32'd7); forward_a = 2'b01; ex_mem_fwd_data = 32'd100;
        push("add_fwd_exmem", 32'd107, 32'd7, 5'd0);
        step();
        plain(5'd0, 32'd5, 32'd7); forward_a = 2'b11; ex_mem_fwd_data = 32'd100;
        push("add_fwd_11", 32'd12, 32'd7, 5'd0);
        step();
        plain(5'd1, 32'd10, 32'd99); forward_b = 2'b10; mem_wb_fwd_data = 32'd3;
        push("sub_fwd_memwb", 32'd7, 32'd3, 5'd1);
        step();
        plain(5'd7, 32'h8000_0000, 32'h55); alu_src_b = 1'b1; imm = 32'h24;
        push("sra_imm", 32'hF800_0000, 32'h55, 5'd7);
        step();
        plain(5'd0, 32'hDEAD, 32'h77); use_pc_a = 1'b1; pc = 32'h1000;
        alu_src_b = 1'b1; imm = 32'h20;
        push("auipc_like", 32'h1020, 32'h77, 5'd0);
        step();

        alu1("and",    5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu1("or",     5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        alu1("xor",    5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu1("sll31",  5'd5,  32'h1,         32'd31,        32'h8000_0000);
        alu1("srl31",  5'd6,  32'h8000_0000, 32'd31,        32'h1);
        alu1("srl33",  5'd6,  32'h8000_0000, 32'd33,        32'h4000_0000);
        alu1("slt_neg",5'd8,  32'hFFFF_FFFF, 32'd1,         32'd1);
        alu1("slt_pos",5'd8,  32'd1,         32'hFFFF_FFFF, 32'd0);
        alu1("sltu",   5'd9,  32'hFFFF_FFFF, 32'd1,         32'd0);
        alu1("pass_b", 5'd10, 32'hAAAA,      32'h1234,      32'h1234);
        alu1("op11",   5'd11, 32'd3,         32'd4,         32'd0);
        alu1("op31",   5'd31, 32'd3,         32'd4,         32'd0);

        // Bubble and flushed instruction must not produce a valid output.
        plain(5'd0, 32'd1, 32'd1); in_valid = 1'b0;
        step();
        chk("bubble_valid", {31'b0, out_valid}, 0);
        chk("bubble_rw", {31'b0, out_reg_write}, 0);
        plain(5'd0, 32'd1, 32'd1); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 0);
        chk("flush_rw", {31'b0, out_reg_write}, 0);

`ifdef EX_MULDIV_EN
        do_iter("mulh",   5'd17, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
        do_iter("div_z",  5'd20, 32'd7,         32'd0,         32'hFFFF_FFFF);
        do_iter("rem_z",  5'd22, 32'd7,         32'd0,         32'd7);
        do_iter("div_ov", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_iter("rem_ov", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_iter("remu",   5'd23, 32'd17,        32'd5,         32'd2);
        do_iter("divu",   5'd21, 32'd100,       32'd7,         32'd14);
        do_iter("div_neg",5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        do_iter("rem_neg",5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        do_iter("mulhu",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_iter("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        step();

        // Flush in BUSY cycle 10, then a single-cycle ADD.
        plain(5'd16, 32'd6, 32'd7);
        repeat (10) step();
        chk("busy_stall", {31'b0, ex_stall}, 1);
        flush = 1'b1;
        #1;
        chk("flush_stall_drop", {31'b0, ex_stall}, 0);
        step();
        flush = 1'b0;
        chk("flush_busy_valid", {31'b0, out_valid}, 0);
        chk("flush_busy_rw", {31'b0, out_reg_write}, 0);
        plain(5'd0, 32'd20, 32'd22);
        push("add_after_flush", 32'd42, 32'd22, 5'd0);
        #1;
        chk("add_after_flush_stall", {31'b0, ex_stall}, 0);
        step();
        chk("add_after_flush_1cyc", {31'b0, out_valid}, 1);
        in_valid = 1'b0;
        step();

        // Reset mid-BUSY, then repeat the multiply.
        plain(5'd16, 32'd6, 32'd7);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rstbusy_valid", {31'b0, out_valid}, 0);
        chk("rstbusy_result", out_result, 0);
        chk("rstbusy_rw", {31'b0, out_reg_write}, 0);
        chk("rstbusy_stall", {31'b0, ex_stall}, 0);
        step();
        do_iter("mul_again", 5'd16, 32'd6, 32'd7, 32'd42);
        in_valid = 1'b0;
`else
        plain(5'd16, 32'd6, 32'd7);
        push("mul_disabled", 32'd0, 32'd7, 5'd16);
        #1;
        chk("mul_disabled_stall", {31'b0, ex_stall}, 0);
        step();
        plain(5'd20, 32'd7, 32'd0);
        push("div_disabled", 32'd0, 32'd0, 5'd20);
        #1;
        chk("div_disabled_stall", {31'b0, ex_stall}, 0);
        step();
        in_valid = 1'b0;
`endif
        repeat (3) step();
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
